pk_history_buffer: RTL

//  Parametrised history store for CG direction vectors p_k: holds the last DEPTH vectors of
//  NUM_EQ elements, newest-first. Lag-0 output is combinational (drop-in for the single-entry

---
 rtl/pk_history_buffer_pkg.sv | 17 +
 rtl/pk_vector_reg.sv | 43 ++++
 rtl/pk_history_buffer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pk_history_buffer_pkg.sv
// ---------------------------------------------------------------------------
// pk_history_buffer_pkg
//   Shared constants for the CG direction-vector history store.
//   Holds the cluster-wide defaults for vector geometry so the storage
//   sub-module and the top agree on element count and element width.
//   No ports.
// ---------------------------------------------------------------------------
package pk_history_buffer_pkg;

  // Equations per cluster = elements per direction vector.
  localparam int NUM_EQ_DEF = 9;
  // Opaque element width; the buffer never does arithmetic on elements.
  localparam int ELEM_W_DEF = 32;
  // Number of stored vectors (must be >= 2).
  localparam int DEPTH_DEF  = 4;

endpackage : pk_history_buffer_pkg

// File: rtl/pk_vector_reg.sv
// ---------------------------------------------------------------------------
// pk_vector_reg
//   One stored direction vector of NUM_EQ elements, ELEM_W bits each.
//   Element i loads from i_d when i_load_all is set or when its bit in
//   i_load_mask is set; otherwise it holds.
// Ports
//   clk          in  rising-edge clock
//   i_load_all   in  load every element (push)
//   i_load_mask  in  per-element load enable (masked overwrite)
//   i_d          in  write vector, element i at [i*ELEM_W +: ELEM_W]
//   o_q          out stored vector
// ---------------------------------------------------------------------------
module pk_vector_reg
  import pk_history_buffer_pkg::*;
#(
  parameter int NUM_EQ = NUM_EQ_DEF,
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic                     clk,
  input  logic                     i_load_all,
  input  logic [NUM_EQ-1:0]        i_load_mask,
  input  logic [NUM_EQ*ELEM_W-1:0] i_d,
  output logic [NUM_EQ*ELEM_W-1:0] o_q
);

  logic [ELEM_W-1:0] r_elem [NUM_EQ];

  for (genvar i = 0; i < NUM_EQ; i++) begin : g_elem
    // NOTE: storage is deliberately not reset; the owner hides stale
    // contents behind its valid-entry count, so a reset here would only
    // add fan-out on the reset net.
    always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every register in the design
      // samples pre-edge values regardless of block evaluation order.
      if (i_load_all || i_load_mask[i]) begin
        r_elem[i] <= i_d[i*ELEM_W +: ELEM_W];
      end
    end

    assign o_q[i*ELEM_W +: ELEM_W] = r_elem[i];
  end

endmodule : pk_vector_reg

// File: rtl/pk_history_buffer.sv
// ---------------------------------------------------------------------------
// pk_history_buffer
//   History store for CG direction vectors p_k. Keeps the last DEPTH
//   vectors in a ring, newest first. The head vector is presented
//   combinationally (drop-in for a single-entry store); a registered read
//   port returns the vector k pushes older. The head entry also supports an
//   in-place masked element update.
// Ports
//   clk            in  rising-edge clock
//   rst            in  asynchronous reset, active-high
//   clear          in  synchronous flush, invalidates all entries (wins over write)
//   write_enable   in  write strobe
//   push           in  1: push input_data as new head, 0: masked overwrite of head
//   elem_mask      in  per-element overwrite enable (ignored on push)
//   input_data     in  write vector, element i at [i*ELEM_W +: ELEM_W]
//   read_en        in  lagged read request
//   read_lag       in  0 = newest, k = k pushes older
//   memory_output  out head vector, combinational, 0 when empty
//   read_data      out registered lagged read result
//   read_valid     out one-cycle pulse, the cycle after read_en
//   read_hit       out with read_valid: lag was below count (else read_data = 0)
//   count          out valid entries, 0..DEPTH
//   full           out count == DEPTH
// ---------------------------------------------------------------------------
module pk_history_buffer
  import pk_history_buffer_pkg::*;
#(
  parameter int NUM_EQ = NUM_EQ_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LAG_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     write_enable,
  input  logic                     push,
  input  logic [NUM_EQ-1:0]        elem_mask,
  input  logic [NUM_EQ*ELEM_W-1:0] input_data,
  input  logic                     read_en,
  input  logic [LAG_W-1:0]         read_lag,
  output logic [NUM_EQ*ELEM_W-1:0] memory_output,
  output logic [NUM_EQ*ELEM_W-1:0] read_data,
  output logic                     read_valid,
  output logic                     read_hit,
  output logic [LAG_W:0]           count,
  output logic                     full
);

  localparam int VEC_W = NUM_EQ * ELEM_W;

  logic [LAG_W-1:0] r_head;
  logic [LAG_W:0]   r_count;
  logic [VEC_W-1:0] r_read_data;
  logic             r_read_valid;
  logic             r_read_hit;

  logic [VEC_W-1:0] w_entry [DEPTH];
  logic [LAG_W-1:0] w_next_head;
  logic [LAG_W-1:0] w_lag_idx;
  logic             w_push;
  logic             w_overwrite;
  logic             w_hit;
  logic             w_empty;

  // clear drops any same-cycle write; an overwrite into an empty buffer
  // has no head entry to modify and is dropped as well.
  assign w_empty     = (r_count == '0);
  assign w_push      = write_enable && !clear && push;
  assign w_overwrite = write_enable && !clear && !push && !w_empty;

  // Explicit wrap keeps the ring correct when DEPTH is not a power of two.
  assign w_next_head = (r_head == LAG_W'(DEPTH - 1)) ? '0 : r_head + LAG_W'(1);

  // ---- storage ring -------------------------------------------------------
  for (genvar j = 0; j < DEPTH; j++) begin : g_entry
    logic             w_load_all;
    logic [NUM_EQ-1:0] w_load_mask;

    assign w_load_all  = w_push && (w_next_head == LAG_W'(j));
    assign w_load_mask = (w_overwrite && (r_head == LAG_W'(j))) ? elem_mask : '0;

    pk_vector_reg #(
      .NUM_EQ (NUM_EQ),
      .ELEM_W (ELEM_W)
    ) u_vec (
      .clk         (clk),
      .i_load_all  (w_load_all),
      .i_load_mask (w_load_mask),
      .i_d         (input_data),
      .o_q         (w_entry[j])
    );
  end

  // ---- lagged read address ------------------------------------------------
  // Entry for lag k is (head - k) mod DEPTH. Only used on a hit, where
  // k < count <= DEPTH, so the wrapped index is always in range.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // the output unassigned, which would infer a latch.
    w_lag_idx = r_head - read_lag;
    if (read_lag > r_head) begin
      w_lag_idx = LAG_W'(int'(r_head) + DEPTH - int'(read_lag));
    end
  end

  assign w_hit = ({1'b0, read_lag} < r_count);

  // ---- pointer, count and read-port registers -----------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head       <= '0;
      r_count      <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_read_hit   <= 1'b0;
    end else begin
      if (clear) begin
        r_count <= '0;
      end else if (w_push) begin
        r_head <= w_next_head;
        if (r_count != (LAG_W+1)'(DEPTH)) begin
          r_count <= r_count + (LAG_W+1)'(1);
        end
      end

      // The read samples pre-edge state, so a coincident write or clear is
      // not visible to it (read-before-write).
      r_read_valid <= read_en;
      r_read_hit   <= read_en && w_hit;
      if (read_en) begin
        r_read_data <= w_hit ? w_entry[w_lag_idx] : '0;
      end
    end
  end

  // ---- outputs ------------------------------------------------------------
  assign memory_output = w_empty ? '0 : w_entry[r_head];
  assign read_data     = r_read_data;
  assign read_valid    = r_read_valid;
  assign read_hit      = r_read_hit;
  assign count         = r_count;
  assign full          = (r_count == (LAG_W+1)'(DEPTH));

endmodule : pk_history_buffer
